// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for a single-output PLL: pulses the PLL reset, qualifies the
// synchronized lock flag over a stability window, then releases the downstream reset.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20,
  parameter int RETRY_W       = 4
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = '1;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic               sync1;
  logic               lk_s;
  logic               go_rst;

  assign state_o = state;

  // Every path back into PLL_RST (relock request, timeout, loss of lock) funnels
  // through go_rst, so a coincident request and lock drop cause one transition.
  always_comb begin
    go_rst = 1'b0;
    case (state)
      WAIT_LOCK: go_rst = relock_req || (!lk_s && (timer == TIMEOUT_LAST));
      STABLE:    go_rst = relock_req;
      RUN:       go_rst = relock_req || !lk_s;
      default:   go_rst = 1'b0;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      lk_s        <= 1'b0;
      state       <= PLL_RST;
      timer       <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      sync1     <= locked;
      lk_s      <= sync1;
      lock_lost <= 1'b0;
      if (go_rst) begin
        state     <= PLL_RST;
        timer     <= '0;
        pll_rst   <= 1'b1;
        sys_rst   <= 1'b1;
        ready     <= 1'b0;
        lock_lost <= (state == RUN) && !lk_s;
        if (retry_count != RETRY_MAX)
          retry_count <= retry_count + RETRY_W'(1);
      end else begin
        case (state)
          PLL_RST: begin
            if (timer == RST_LAST) begin
              state   <= WAIT_LOCK;
              timer   <= '0;
              pll_rst <= 1'b0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (lk_s) begin
              state <= STABLE;
              timer <= '0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          STABLE: begin
            // A lock drop wins even on the last window cycle: the window must be clean.
            if (!lk_s) begin
              state <= WAIT_LOCK;
              timer <= '0;
            end else if (timer == STABLE_LAST) begin
              state   <= RUN;
              timer   <= '0;
              sys_rst <= 1'b0;
              ready   <= 1'b1;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          default: begin
            timer <= timer;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Latencies are counted in rising edges from the point an input is driven (1 ns after an edge).
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (20),
    .RETRY_W      (4)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .state_o    (state_o)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? pll_rst : ready;
  endfunction

  // Count edges until the selected output (0=pll_rst, 1=ready) reaches val; n==limit on expiry.
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (n < limit && sig(sel) !== val) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    relock_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; relock_req = 1'b0;
    tick(2);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    $display("test_reset: state=%0d pll_rst=%b sys_rst=%b", state_o, pll_rst, sys_rst);
  endtask

  task automatic test_bring_up();
    int n;
    locked = 1'b0;
    do_reset();
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bringup_pll_rst_len: got %0d expected 4", n); end
    tick(3);
    locked = 1'b1;
    // 1 sampling edge + 2 sync/decide edges + 8 stable cycles
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL bringup_ready_latency: got %0d expected 11", n); end
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL bringup_sys_rst: got %b expected 0", sys_rst); end
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL bringup_state: got %0d expected 3", state_o); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL bringup_retry: got %0d expected 0", retry_count); end
    $display("test_bring_up: ready after %0d edges", n);
  endtask

  task automatic test_timeout();
    int n;
    int exp;
    locked = 1'b0;
    do_reset();
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL timeout_first_pulse: got %0d expected 4", n); end
    for (int i = 1; i <= 16; i++) begin
      exp = (i > 15) ? 15 : i;
      wait_for(0, 1'b1, 60, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL timeout_wait_len[%0d]: got %0d expected 20", i, n); end
      checks++; if (retry_count !== 4'(exp)) begin errors++; $display("FAIL timeout_retry[%0d]: got %0d expected %0d", i, retry_count, exp); end
      wait_for(0, 1'b0, 60, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL timeout_pulse_len[%0d]: got %0d expected 4", i, n); end
      $display("test_timeout: attempt %0d retry_count=%0d", i, retry_count);
    end
    checks++; if (ready !== 1'b0 || sys_rst !== 1'b1) begin errors++; $display("FAIL timeout_outputs: got ready=%b sys_rst=%b expected 0/1", ready, sys_rst); end
  endtask

  task automatic test_glitch_stable();
    int n;
    locked = 1'b0;
    do_reset();
    wait_for(0, 1'b0, 50, n);
    locked = 1'b1;
    tick(3);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL glitch_enter_stable: got %0d expected 2", state_o); end
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    // drop reaches the FSM on the last window cycle; it must still fall back
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL glitch_back_to_wait: got %0d expected 1", state_o); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_early: got %b expected 0", ready); end
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL glitch_ready_latency: got %0d expected 9", n); end
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL glitch_retry: got %0d expected 0", retry_count); end
    $display("test_glitch_stable: ready after %0d edges, retry_count=%0d", n, retry_count);
  endtask

  task automatic test_loss_in_run();
    int n;
    locked = 1'b0;
    tick(2);
    checks++; if (lock_lost !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL loss_early: got lock_lost=%b ready=%b expected 0/1", lock_lost, ready); end
    tick(1);
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %b expected 1", lock_lost); end
    checks++; if (sys_rst !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL loss_sys_rst: got sys_rst=%b ready=%b expected 1/0", sys_rst, ready); end
    checks++; if (pll_rst !== 1'b1 || state_o !== 2'd0) begin errors++; $display("FAIL loss_pll_rst: got pll_rst=%b state=%0d expected 1/0", pll_rst, state_o); end
    checks++; if (retry_count !== 4'd1) begin errors++; $display("FAIL loss_retry: got %0d expected 1", retry_count); end
    tick(1);
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_pulse_width: got %b expected 0", lock_lost); end
    locked = 1'b1;
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL loss_pll_rst_rest: got %0d expected 3", n); end
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL loss_ready_again: got %0d expected 9", n); end
    $display("test_loss_in_run: re-run reached, retry_count=%0d", retry_count);
  endtask

  task automatic test_relock();
    int n;
    locked = 1'b1;
    do_reset();
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 13) begin errors++; $display("FAIL relock_bring_up: got %0d expected 13", n); end
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++; if (state_o !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL relock_enter: got state=%0d pll_rst=%b expected 0/1", state_o, pll_rst); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL relock_no_lost: got %b expected 0", lock_lost); end
    checks++; if (retry_count !== 4'd1) begin errors++; $display("FAIL relock_retry: got %0d expected 1", retry_count); end
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++; if (retry_count !== 4'd1) begin errors++; $display("FAIL relock_ignored_retry: got %0d expected 1", retry_count); end
    wait_for(0, 1'b0, 50, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL relock_pll_rst_len: got %0d more edges expected 2", n); end
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL relock_ready_again: got %0d expected 9", n); end
    $display("test_relock: retry_count=%0d", retry_count);
  endtask

  task automatic test_back_to_back();
    locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL b2b_lock_lost: got %b expected 1", lock_lost); end
    checks++; if (retry_count !== 4'd2) begin errors++; $display("FAIL b2b_retry: got %0d expected 2", retry_count); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL b2b_state: got %0d expected 0", state_o); end
    tick(1);
    checks++; if (lock_lost !== 1'b0 || retry_count !== 4'd2) begin errors++; $display("FAIL b2b_single: got lock_lost=%b retry=%0d expected 0/2", lock_lost, retry_count); end
    $display("test_back_to_back: retry_count=%0d", retry_count);
  endtask

  task automatic test_async_reset();
    int n;
    locked = 1'b1;
    do_reset();
    tick(7);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(7);
    checks++; if (state_o !== 2'd2 || retry_count !== 4'd1) begin errors++; $display("FAIL async_setup: got state=%0d retry=%0d expected 2/1", state_o, retry_count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1 || sys_rst !== 1'b1) begin errors++; $display("FAIL async_resets: got pll_rst=%b sys_rst=%b expected 1/1", pll_rst, sys_rst); end
    checks++; if (ready !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL async_flags: got ready=%b lock_lost=%b expected 0/0", ready, lock_lost); end
    checks++; if (retry_count !== 4'd0 || state_o !== 2'd0) begin errors++; $display("FAIL async_state: got retry=%0d state=%0d expected 0/0", retry_count, state_o); end
    tick(1);
    rst = 1'b0;
    wait_for(1, 1'b1, 60, n);
    checks++; if (n !== 13) begin errors++; $display("FAIL async_restart: got %0d expected 13", n); end
    $display("test_async_reset: restarted, ready after %0d edges", n);
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_timeout();
    test_glitch_stable();
    test_loss_in_run();
    test_relock();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
